parity_gen_chk: RTL and testbench
=================================

# parity_gen_chk

Parametrised, serial even/odd parity generator and checker. A word of `DATA_W` bits is captured on `start` and scanned one bit per clock, LSB first. In generate mode the block emits the word with its parity bit appended. In check mode it also compares the computed parity against a supplied parity bit and flags a mismatch. It replaces the fixed 5-bit even-only parity block in the same datapath position, between the data source and the serial/line encoder.

## Interface
Parameters:
- `DATA_W`, 8, payload width in bits; legal range 2..32.

Ports:
- `clk`, input, 1, single clock; all state changes on the rising edge.
- `n_rst`, input, 1, asynchronous active-low reset.
- `start`, input, 1, request pulse; sampled only in IDLE.
- `data`, input, `DATA_W`, payload; captured when `start` is accepted.
- `parity_in`, input, 1, received parity bit; captured with `data`; used only in check mode.
- `odd_sel`, input, 1, parity type: 0 = even, 1 = odd; captured with `data`.
- `check_en`, input, 1, mode: 0 = generate, 1 = check; captured with `data`.
- `busy`, output, 1, high whenever state is not IDLE.
- `done`, output, 1, one-cycle pulse when a result is valid.
- `code_out`, output, `DATA_W+1`, result word `{parity, data}`; parity is the MSB.
- `parity_err`, output, 1, check-mode mismatch; 0 in generate mode.

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE -> CALC when `start`=1. On that edge:
  - capture `data`, `parity_in`, `odd_sel` and `check_en` into a shadow register;
  - clear the accumulator and the bit counter.
- CALC, each edge:
  - accumulator ^= shadow bit[cnt];
  - cnt increments; cnt is `$clog2(DATA_W)` bits wide.
- CALC -> DONE on the edge where cnt = `DATA_W-1`. On that same edge:
  - compute p = acc ^ bit[DATA_W-1] ^ odd_sel;
  - load `code_out` <= {p, shadow data};
  - load `parity_err` <= check_en & (p != parity_in);
  - set `done` <= 1.
- DONE -> IDLE unconditionally on the next edge; `done` returns to 0.
- `code_out` and `parity_err` hold their values until the next DONE entry or reset.
- `start` in CALC or DONE is ignored; no queuing. Changes to `data` or mode inputs after capture have no effect on the current operation.
- Parity definitions:
  - even: p = XOR of all data bits;
  - odd: p = inverted XOR of all data bits.
- Reset (`n_rst`=0, any time, including mid-CALC):
  - state <= IDLE;
  - `busy`, `done`, `parity_err`, `code_out`, accumulator, counter and shadow register all <= 0;
  - an operation in progress is discarded and no `done` is produced.

## Timing
- `start` sampled high at edge E0.
- `busy` is high from after E0 until after edge E(DATA_W+1).
- `done` is high for exactly one cycle, between edges E(DATA_W) and E(DATA_W+1).
- The result appears on `code_out` and `parity_err` at E(DATA_W).
- Earliest next accepted `start` is at edge E(DATA_W+2). Throughput: one word per DATA_W+2 cycles.
- All outputs are registered; no combinational path from inputs to outputs.
- Reset release is synchronised by the system; the first `start` may be sampled at the first edge with `n_rst`=1.

## Test plan
All scenarios use `DATA_W`=5, 10-unit clock, and reset released mid-cycle.
- Generate, even:
  - `data`=0x01 -> `code_out`=0x21, `parity_err`=0, `done` 5 cycles after `start`;
  - `data`=0x17 -> 0x17;
  - `data`=0x0E -> 0x2E.
- Generate, odd (`odd_sel`=1): 0x17 -> 0x37; 0x0E -> 0x0E; 0x00 -> 0x20.
- Check, even (`check_en`=1):
  - `data`=0x17, `parity_in`=0 -> `parity_err`=0;
  - `parity_in`=1 -> `parity_err`=1, `code_out`=0x17.
- Ignored start:
  - second `start` with `data`=0x1F pulsed 2 cycles after the first (0x01) -> exactly one `done`, `code_out`=0x21;
  - a `start` in the DONE cycle is also ignored.
- Reset mid-CALC: assert `n_rst`=0 three cycles after `start` -> `busy`, `done`, `code_out`, `parity_err` are 0 immediately; no `done` afterwards; the next `start` with `data`=0x0E gives 0x2E.
- Back-to-back: `start` at E0 and at E(DATA_W+2) with 0x01 then 0x0E -> two `done` pulses 7 cycles apart, results 0x21 then 0x2E.

Source files
------------

// File: rtl/parity_gen_chk.sv
// Serial even/odd parity generator and checker.
// Scans a captured word LSB first and emits {parity, data} with a mismatch flag.
module parity_gen_chk #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic [DATA_W-1:0] data,
    input  logic              parity_in,
    input  logic              odd_sel,
    input  logic              check_en,
    output logic              busy,
    output logic              done,
    output logic [DATA_W:0]   code_out,
    output logic              parity_err
);

    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shd_data_q, shd_data_d;
    logic              shd_par_q, shd_par_d;
    logic              shd_odd_q, shd_odd_d;
    logic              shd_chk_q, shd_chk_d;
    logic              acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W:0]   code_q, code_d;
    logic              err_q, err_d;
    logic              done_q, done_d;
    logic              bit_cur;
    logic              par;

    always_comb begin
        state_d    = state_q;
        shd_data_d = shd_data_q;
        shd_par_d  = shd_par_q;
        shd_odd_d  = shd_odd_q;
        shd_chk_d  = shd_chk_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        code_d     = code_q;
        err_d      = err_q;
        done_d     = 1'b0;
        bit_cur    = shd_data_q[cnt_q];
        par        = acc_q ^ bit_cur ^ shd_odd_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = CALC;
                    shd_data_d = data;
                    shd_par_d  = parity_in;
                    shd_odd_d  = odd_sel;
                    shd_chk_d  = check_en;
                    acc_d      = 1'b0;
                    cnt_d      = '0;
                end
            end
            CALC: begin
                acc_d = acc_q ^ bit_cur;
                cnt_d = cnt_q + CNT_W'(1);
                // last bit folds straight into the result
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    state_d = DONE;
                    code_d  = {par, shd_data_q};
                    err_d   = shd_chk_q & (par ^ shd_par_q);
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            shd_data_q <= '0;
            shd_par_q  <= 1'b0;
            shd_odd_q  <= 1'b0;
            shd_chk_q  <= 1'b0;
            acc_q      <= 1'b0;
            cnt_q      <= '0;
            code_q     <= '0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shd_data_q <= shd_data_d;
            shd_par_q  <= shd_par_d;
            shd_odd_q  <= shd_odd_d;
            shd_chk_q  <= shd_chk_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            code_q     <= code_d;
            err_q      <= err_d;
            done_q     <= done_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign code_out   = code_q;
    assign parity_err = err_q;

endmodule

// File: tb/tb_parity_gen_chk.sv
// Scoreboard bench for parity_gen_chk with a 5-bit payload.
// Expected results are queued at start and popped when done pulses.
module tb_parity_gen_chk;

    localparam int W = 5;

    logic         clk = 1'b0;
    logic         n_rst = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] data = '0;
    logic         parity_in = 1'b0;
    logic         odd_sel = 1'b0;
    logic         check_en = 1'b0;
    logic         busy;
    logic         done;
    logic [W:0]   code_out;
    logic         parity_err;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [W+1:0] exp_q[$];

    parity_gen_chk #(.DATA_W(W)) dut (
        .clk(clk),
        .n_rst(n_rst),
        .start(start),
        .data(data),
        .parity_in(parity_in),
        .odd_sel(odd_sel),
        .check_en(check_en),
        .busy(busy),
        .done(done),
        .code_out(code_out),
        .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Called at a negedge; start is sampled on the following posedge.
    task automatic start_op(input logic [W-1:0] d, input logic odd,
                            input logic chk, input logic pin,
                            output int t0);
        logic       p;
        logic [W:0] code;
        logic       err;
        p = (^d) ^ odd;
        code = {p, d};
        err = chk & (p != pin);
        exp_q.push_back({err, code});
        data = d;
        odd_sel = odd;
        check_en = chk;
        parity_in = pin;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t0 = cyc;
        data = ~d;
        odd_sel = ~odd;
        check_en = ~chk;
        parity_in = ~pin;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_start: got %b want 1", busy);
        end
    endtask

    task automatic wait_result(input int t0, input logic poke_done,
                               output int tdone);
        logic [W+1:0] e;
        bit           seen;
        seen = 0;
        tdone = 0;
        e = '0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                tdone = cyc;
                e = exp_q.pop_front();
                checks++;
                if (code_out !== e[W:0]) begin
                    errors++;
                    $display("FAIL code_out: got %h want %h", code_out, e[W:0]);
                end
                checks++;
                if (parity_err !== e[W+1]) begin
                    errors++;
                    $display("FAIL parity_err: got %b want %b", parity_err, e[W+1]);
                end
                checks++;
                if (cyc - t0 !== W) begin
                    errors++;
                    $display("FAIL latency: got %0d want %0d", cyc - t0, W);
                end
                if (poke_done) begin
                    data = 5'h1F;
                    start = 1'b1;
                end
            end
        end
        if (!seen) begin
            errors++;
            checks++;
            $display("FAIL done_timeout: got no done want done");
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL after_done: got done=%b busy=%b want 0 0", done, busy);
        end
        checks++;
        if (seen && (code_out !== e[W:0] || parity_err !== e[W+1])) begin
            errors++;
            $display("FAIL hold: got %h/%b want %h/%b",
                     code_out, parity_err, e[W:0], e[W+1]);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL idle: got done=%b busy=%b want 0 0", done, busy);
            end
        end
    endtask

    task automatic op(input logic [W-1:0] d, input logic odd,
                      input logic chk, input logic pin);
        int t0;
        int td;
        start_op(d, odd, chk, pin, t0);
        wait_result(t0, 1'b0, td);
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || code_out !== '0 || parity_err !== 1'b0) begin
            errors++;
            $display("FAIL reset: got busy=%b done=%b code=%h err=%b want 0 0 00 0",
                     busy, done, code_out, parity_err);
        end
        @(negedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        idle_cycles(2);
    endtask

    task automatic test_gen_even;
        op(5'h01, 1'b0, 1'b0, 1'b0);
        op(5'h17, 1'b0, 1'b0, 1'b1);
        op(5'h0E, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_gen_odd;
        op(5'h17, 1'b1, 1'b0, 1'b0);
        op(5'h0E, 1'b1, 1'b0, 1'b1);
        op(5'h00, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_check;
        op(5'h17, 1'b0, 1'b1, 1'b0);
        op(5'h17, 1'b0, 1'b1, 1'b1);
        op(5'h0E, 1'b1, 1'b1, 1'b1);
        op(5'h00, 1'b1, 1'b1, 1'b1);
    endtask

    task automatic test_ignored_start;
        int t0;
        int td;
        start_op(5'h01, 1'b0, 1'b0, 1'b0, t0);
        @(negedge clk);
        data = 5'h1F;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_result(t0, 1'b1, td);
        idle_cycles(9);
    endtask

    task automatic test_reset_mid;
        int t0;
        int td;
        start_op(5'h17, 1'b1, 1'b1, 1'b0, t0);
        void'(exp_q.pop_back());
        @(negedge clk);
        @(negedge clk);
        n_rst = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || code_out !== '0 || parity_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got busy=%b done=%b code=%h err=%b want 0 0 00 0",
                     busy, done, code_out, parity_err);
        end
        @(negedge clk);
        n_rst = 1'b1;
        idle_cycles(8);
        start_op(5'h0E, 1'b0, 1'b0, 1'b0, t0);
        wait_result(t0, 1'b0, td);
    endtask

    task automatic test_back_to_back;
        int t0;
        int t1;
        int d0;
        int d1;
        start_op(5'h01, 1'b0, 1'b0, 1'b0, t0);
        wait_result(t0, 1'b0, d0);
        start_op(5'h0E, 1'b0, 1'b0, 1'b0, t1);
        wait_result(t1, 1'b0, d1);
        checks++;
        if (d1 - d0 !== W + 2) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d want %0d", d1 - d0, W + 2);
        end
    endtask

    initial begin
        test_reset;
        test_gen_even;
        test_gen_odd;
        test_check;
        test_ignored_start;
        test_reset_mid;
        test_back_to_back;
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_left: got %0d want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
